// File: rtl/multiplier.sv
// Iterative 32-round shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Borrows the shared ALU adder; signed forms run on magnitudes and are negated at the end.
module multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_en_i,
  input  logic [2:0]  funct3_32,
  input  logic [31:0] muldiv_a_i,
  input  logic [31:0] muldiv_b_i,
  input  logic [33:0] adder_result_ext_i,
  output logic [31:0] mul_operand_a_o,
  output logic [31:0] mul_operand_b_o,
  output logic        mul_add_o,
  output logic        mul_busy_o,
  output logic        mul_finish_o,
  output logic [31:0] muldiv_result_o
);

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_NEG, S_DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] product;
  logic [31:0] mcand;
  logic [4:0]  round;
  logic [2:0]  op;
  logic        neg;
  logic        sa;
  logic        sb;
  logic        unused_adder_lsb;

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic s);
    return s ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  assign unused_adder_lsb = adder_result_ext_i[0];

  always_comb begin
    sa = muldiv_a_i[31] & ((funct3_32 == MULH) | (funct3_32 == MULHSU));
    sb = muldiv_b_i[31] & (funct3_32 == MULH);
  end

  // Next state and outputs; a low request level outside IDLE abandons the operation.
  always_comb begin
    state_nxt       = state;
    mul_operand_a_o = 32'd0;
    mul_operand_b_o = 32'd0;
    mul_add_o       = 1'b0;
    mul_busy_o      = (state != S_IDLE);
    mul_finish_o    = 1'b0;
    case (state)
      S_IDLE: begin
        if (mul_en_i) state_nxt = S_CALC;
      end
      S_CALC: begin
        mul_operand_a_o = product[63:32];
        mul_operand_b_o = mcand;
        mul_add_o       = product[0];
        if (!mul_en_i)          state_nxt = S_IDLE;
        else if (round == 5'd31) state_nxt = neg ? S_NEG : S_DONE;
      end
      S_NEG: begin
        state_nxt = mul_en_i ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        mul_finish_o = mul_en_i;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      product         <= 64'd0;
      mcand           <= 32'd0;
      round           <= 5'd0;
      op              <= 3'd0;
      neg             <= 1'b0;
      muldiv_result_o <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (mul_en_i) begin
            mcand   <= mag32(muldiv_a_i, sa);
            product <= {32'd0, mag32(muldiv_b_i, sb)};
            round   <= 5'd0;
            op      <= funct3_32;
            neg     <= sa ^ sb;
          end
        end
        S_CALC: begin
          if (mul_en_i) begin
            // Carry-out of the shared adder becomes the new top bit of the product.
            product <= product[0] ? {adder_result_ext_i[33:1], product[31:1]}
                                  : {1'b0, product[63:1]};
            round   <= round + 5'd1;
          end
        end
        S_NEG: begin
          if (mul_en_i) product <= neg64(product);
        end
        S_DONE: begin
          if (mul_en_i) muldiv_result_o <= (op == MUL) ? product[31:0] : product[63:32];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Randomized and directed bench for the iterative multiplier, with an arithmetic
// reference model and an emulated shared ALU adder.
module tb_multiplier;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  f3;
  logic [31:0] a;
  logic [31:0] b;
  logic [33:0] adder;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        add;
  logic        busy;
  logic        fin;
  logic [31:0] res;

  int n_tests;
  int n_fail;

  // Reference model state seen by the compare process.
  bit          chk_on;
  bit          m_active;
  int          m_k;
  int          m_done;
  logic [31:0] m_maga;
  logic [31:0] m_magb;
  logic [31:0] m_res;
  logic [31:0] pend_res;

  multiplier dut (
    .clk                (clk),
    .rst                (rst),
    .mul_en_i           (en),
    .funct3_32          (f3),
    .muldiv_a_i         (a),
    .muldiv_b_i         (b),
    .adder_result_ext_i (adder),
    .mul_operand_a_o    (opa),
    .mul_operand_b_o    (opb),
    .mul_add_o          (add),
    .mul_busy_o         (busy),
    .mul_finish_o       (fin),
    .muldiv_result_o    (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: sum in bits [32:1], carry-out in bit 33.
  assign adder = {({1'b0, opa} + {1'b0, opb}), 1'b0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic calc;
    if (chk_on) begin
      calc = m_active && (m_k >= 1) && (m_k <= 32);
      chk("busy", busy, m_active && (m_k >= 1) && (m_k <= m_done));
      chk("finish", fin, m_active && (m_k == m_done));
      chk("add", add, calc ? m_magb[m_k-1] : 1'b0);
      chk("operand_b", opb, calc ? m_maga : 32'd0);
      if (!calc) chk("operand_a", opa, 32'd0);
      chk("result", res, m_res);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b0; en = 1'b0;
      f3 = 3'($urandom); a = $urandom; b = $urandom;
      m_active = 1'b0; m_res = pend_res;
    end
  endtask

  // stop_k >= 0 ends the operation early at that cycle: abort (en low) or reset.
  task automatic do_op(input logic [2:0] op, input logic [31:0] ia, input logic [31:0] ib,
                       input int stop_k, input bit stop_rst, output int fin_k, output int add_cnt);
    logic sa, sb;
    logic signed [65:0] pa, pb, pp;
    logic [63:0] prod;
    logic [31:0] newres;
    int done;
    sa = ia[31] && (op == 3'd1 || op == 3'd2);
    sb = ib[31] && (op == 3'd1);
    pa = sa ? $signed({{34{1'b1}}, ia}) : $signed({34'd0, ia});
    pb = sb ? $signed({{34{1'b1}}, ib}) : $signed({34'd0, ib});
    pp = pa * pb;
    prod = pp[63:0];
    newres = (op == 3'd0) ? prod[31:0] : prod[63:32];
    done = (sa ^ sb) ? 34 : 33;
    fin_k = -1;
    add_cnt = 0;
    for (int k = 0; k <= done; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        f3 = op; a = ia; b = ib;
      end else begin
        f3 = 3'($urandom); a = $urandom; b = $urandom;
      end
      en  = !(k == stop_k && !stop_rst);
      rst = (k == stop_k) && stop_rst;
      m_active = 1'b1; m_k = k; m_done = done; m_res = pend_res;
      m_maga = sa ? (32'd0 - ia) : ia;
      m_magb = sb ? (32'd0 - ib) : ib;
      @(negedge clk);
      if (fin && fin_k < 0) fin_k = k;
      if (add) add_cnt++;
      if (k == stop_k) begin
        if (stop_rst) pend_res = 32'd0;
        return;
      end
    end
    pend_res = newres;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int fk, ac;
    n_tests = 0; n_fail = 0;
    chk_on = 1'b0; m_active = 1'b0; m_k = 0; m_done = 0;
    m_maga = 0; m_magb = 0; m_res = 0; pend_res = 0;
    rst = 1'b1; en = 1'b0; f3 = 3'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    @(posedge clk); #1;
    chk("reset_result", res, 32'd0);
    chk("reset_busy", busy, 1'b0);
    idle(2);

    do_op(3'd0, 32'd7, 32'd6, -1, 1'b0, fk, ac);
    chk("mul7x6_fin_cycle", fk, 33);
    chk("mul7x6_add_count", ac, 2);
    idle(1);
    chk("mul7x6_result", res, 32'h0000_002A);

    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, fk, ac);
    chk("mulhu_fin_cycle", fk, 33);
    idle(1);
    chk("mulhu_result", res, 32'hFFFF_FFFE);

    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, fk, ac);
    chk("mulhsu_fin_cycle", fk, 34);
    idle(1);
    chk("mulhsu_result", res, 32'hFFFF_FFFF);

    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, -1, 1'b0, fk, ac);
    chk("mulh_minmin_fin_cycle", fk, 33);
    idle(1);
    chk("mulh_minmin_result", res, 32'h4000_0000);

    do_op(3'd1, 32'h8000_0000, 32'h0000_0001, -1, 1'b0, fk, ac);
    chk("mulh_minone_fin_cycle", fk, 34);
    idle(1);
    chk("mulh_minone_result", res, 32'hFFFF_FFFF);

    do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10, 1'b0, fk, ac);
    chk("abort_no_finish", fk, -1);
    idle(1);
    chk("abort_idle_busy", busy, 1'b0);
    chk("abort_result_kept", res, 32'hFFFF_FFFF);
    do_op(3'd0, 32'd3, 32'd5, -1, 1'b0, fk, ac);
    chk("restart_fin_cycle", fk, 33);
    idle(1);
    chk("restart_result", res, 32'd15);

    do_op(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 15, 1'b1, fk, ac);
    idle(1);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_result", res, 32'd0);
    chk("rst_mid_add", add, 1'b0);
    chk("rst_mid_operand_b", opb, 32'd0);
    do_op(3'd0, 32'd100, 32'd200, -1, 1'b0, fk, ac);
    chk("after_rst_fin_cycle", fk, 33);
    idle(1);
    chk("after_rst_result", res, 32'd20000);

    do_op(3'd1, 32'hFFFF_FFFD, 32'd7, -1, 1'b0, fk, ac);
    do_op(3'd0, 32'hFFFF_FFFD, 32'd7, -1, 1'b0, fk, ac);
    idle(1);
    chk("b2b_mul_result", res, 32'hFFFF_FFEB);

    for (int i = 0; i < 24; i++) begin
      do_op(3'($urandom_range(0, 3)), rnd32(), rnd32(), -1, 1'b0, fk, ac);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
